// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: per-cycle stall/flush/bubble
// decisions for load-use hazards, taken branches in MEM and multi-cycle memory accesses.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;
    logic              mem_wait;
    logic              stall_inc;
    logic              flush_inc;

    // mem_req/mem_ready: an access completes in the cycle both are high; req high
    // with ready low freezes the whole pipe until ready arrives or req drops.
    assign mem_wait = mem_req & ~mem_ready;
    assign lu = ex_memread & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign state = state_q;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_bubble = 1'b0;
        state_nxt    = RUN;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_nxt   = MEM_WAIT;
            stall_inc   = 1'b1;
        end else if (mem_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            flush_inc    = 1'b1;
        end else if (lu && state_q != LU_STALL) begin
            // LU_STALL masks detection so the hazard costs exactly one bubble
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = LU_STALL;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (stall_inc && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
            if (mem_wait) begin
                if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
                    wait_cnt <= wait_cnt + 1'b1;
                // sets on the edge where the count reaches MEM_TIMEOUT
                if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule
